alu7_seq: RTL and testbench

//  - Sequential 7-bit unsigned add/subtract unit with flags. One operation per start pulse.
//  - Small control FSM captures operands, computes, then presents a registered result.
//  - Sits between a controller FSM (issues start/op) and a consumer that samples on done.

---
 rtl/alu7_seq_if.sv | 26 ++
 rtl/alu7_seq.sv | 117 +++++++++++
 tb/tb_alu7_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu7_seq_if.sv
// Bus between the issuing controller and the alu7_seq add/subtract unit.
// The controller drives the request and operands. The unit returns a registered
// result, the CF/GZ flags and the busy/done status.
interface alu7_seq_if #(
  parameter int W = 7
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic [W-1:0] res;
  logic         CF;
  logic         GZ;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b, op,
    input  res, CF, GZ, busy, done
  );

  modport slave (
    input  start, a, b, op,
    output res, CF, GZ, busy, done
  );
endinterface

// File: rtl/alu7_seq.sv
// alu7_seq: sequential unsigned add/subtract unit with carry/borrow (CF) and
// non-zero (GZ) flags. Each start pulse runs one operation through
// IDLE -> LOAD -> EXEC -> DONE. The result is valid 3 clock edges after start.
// Optional build macro ALU7_SAT_EN selects saturating results instead of
// modulo-2^W wrap-around:
//   - an add that carries clamps to all-ones;
//   - a subtract that borrows clamps to zero.
module alu7_seq #(
  parameter int   W      = 7,
  parameter logic SUB_OP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  alu7_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         op_q, op_d;
  logic [W-1:0] res_q, res_d;
  logic         cf_q, cf_d;
  logic         gz_q, gz_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W:0]   arith;

  // W+1-bit arithmetic on the captured operands. Bit W holds the add carry or the subtract borrow.
  always_comb begin
    if (op_q == SUB_OP) arith = {1'b0, a_q} - {1'b0, b_q};
    else                arith = {1'b0, a_q} + {1'b0, b_q};
  end

  // Next-state and next-output logic for the control FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no path can leave a latch behind.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cf_d    = cf_q;
    gz_d    = gz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        a_d     = bus.a;
        b_d     = bus.b;
        op_d    = bus.op;
        busy_d  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cf_d = arith[W];
`ifdef ALU7_SAT_EN
        if (arith[W]) res_d = (op_q == SUB_OP) ? '0 : {W{1'b1}};
        else          res_d = arith[W-1:0];
`else
        res_d = arith[W-1:0];
`endif
        gz_d    = (res_d != '0);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, captured operands and registered outputs. Reset is synchronous and wins over start.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_IDLE;
      // NOTE: the operand registers are reset too, so an aborted operation leaves nothing stale behind.
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      gz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      gz_q    <= gz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.res  = res_q;
  assign bus.CF   = cf_q;
  assign bus.GZ   = gz_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_alu7_seq.sv
// Self-checking bench for alu7_seq. It runs directed cases first and then random
// operations. A behavioural integer model predicts the results.
// Stimulus is driven on the falling edge. Outputs are sampled on the falling edge.
module tb_alu7_seq;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu7_seq_if #(.W(7)) bus ();

  alu7_seq #(.W(7), .SUB_OP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Abort the run if it ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic void model(input int av, input int bv, input bit opv,
                                output int r, output int cf, output int gz);
    int full;
    full = opv ? (av - bv) : (av + bv);
    cf   = (full > 127 || full < 0) ? 1 : 0;
    r    = (full + 128) % 128;
`ifdef ALU7_SAT_EN
    if (cf == 1) r = opv ? 0 : 127;
`endif
    gz = (r != 0) ? 1 : 0;
  endfunction

  // Runs one operation. It is called at a falling edge while the unit is idle, and returns at the falling edge of the following IDLE cycle.
  task automatic run_op(input string tag, input logic [6:0] av, input logic [6:0] bv, input logic opv);
    int er, ec, eg;
    model(int'(av), int'(bv), opv, er, ec, eg);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.op    = opv;
    @(posedge clk); @(negedge clk);            // LOAD
    bus.start = 1'b0;
    check({tag, "_load_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_load_done"}, 32'(bus.done), 32'd0);
    @(posedge clk); @(negedge clk);            // EXEC: scramble inputs, poke start
    bus.a     = 7'($urandom);
    bus.b     = 7'($urandom);
    bus.op    = ~opv;
    bus.start = 1'b1;
    check({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_exec_done"}, 32'(bus.done), 32'd0);
    @(posedge clk); @(negedge clk);            // DONE
    bus.start = 1'b0;
    check({tag, "_done"},      32'(bus.done), 32'd1);
    check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_res"},       32'(bus.res),  32'(er));
    check({tag, "_cf"},        32'(bus.CF),   32'(ec));
    check({tag, "_gz"},        32'(bus.GZ),   32'(eg));
    @(posedge clk); @(negedge clk);            // IDLE: pulse over, result held
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_hold_res"},  32'(bus.res),  32'(er));
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = 1'b0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res",  32'(bus.res),  32'd0);
    check("rst_cf",   32'(bus.CF),   32'd0);
    check("rst_gz",   32'(bus.GZ),   32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back-to-back.
    run_op("add_nc",  7'd20,  7'd30, 1'b0);
    run_op("add_c",   7'd100, 7'd60, 1'b0);
    run_op("sub_bor", 7'd5,   7'd9,  1'b1);
    run_op("sub_eq",  7'd77,  7'd77, 1'b1);
    run_op("add_nz",  7'd20,  7'd30, 1'b0);    // leaves res nonzero before the abort

    // Reset during EXEC aborts the operation, clears the outputs and produces no done pulse.
    bus.start = 1'b1; bus.a = 7'd1; bus.b = 7'd1; bus.op = 1'b0;
    @(posedge clk); @(negedge clk);            // LOAD
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);            // EXEC
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_res",  32'(bus.res),  32'd0);
    check("abort_cf",   32'(bus.CF),   32'd0);
    check("abort_gz",   32'(bus.GZ),   32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    // Reset and start in the same cycle: reset wins and nothing starts.
    rst = 1'b1; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_start_busy", 32'(bus.busy), 32'd0);
      check("rst_start_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    // The unit is back in IDLE and takes a fresh operation.
    run_op("post_rst", 7'd1, 7'd1, 1'b0);

    // Random operations.
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("rnd%0d", i), 7'($urandom_range(0, 127)),
             7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
